// File: rtl/step_enable_gen_if.sv
// Signal bundle between the clock visualizer, the operator controls and the core enables.
interface step_enable_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             s_clk;
  logic             run_sw;
  logic             step_btn;
  logic             cpu_en;
  logic             running;
  logic [CNT_W-1:0] step_count;

  modport master (
    output s_clk, run_sw, step_btn,
    input  cpu_en, running, step_count
  );

  modport slave (
    input  s_clk, run_sw, step_btn,
    output cpu_en, running, step_count
  );
endinterface

// File: rtl/step_enable_gen.sv
// Re-times the slow visual clock into single-cycle cpu_en pulses on clk, with
// run/pause from a switch and single-step from a debounced push button.
module step_enable_gen #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  step_enable_gen_if.slave bus
);

  localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {PAUSED, RUN, STEP} state_t;

  logic [SYNC_STAGES-1:0] s_chain;
  logic [SYNC_STAGES-1:0] run_chain;
  logic [SYNC_STAGES-1:0] btn_chain;
  logic                   s_sync;
  logic                   s_prev;
  logic                   run_s;
  logic                   btn_s;
  logic                   tick;

  logic [DB_W-1:0]        db_cnt;
  logic                   stable;
  logic                   press;

  state_t                 state;
  logic                   cpu_en_q;
  logic                   running_q;
  logic [CNT_W-1:0]       step_count_q;

  assign s_sync = s_chain[SYNC_STAGES-1];
  assign run_s  = run_chain[SYNC_STAGES-1];
  assign btn_s  = btn_chain[SYNC_STAGES-1];
  assign tick   = s_sync & ~s_prev;

  // s_clk history loads all ones so a level already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_chain   <= '1;
      s_prev    <= 1'b1;
      run_chain <= '0;
      btn_chain <= '0;
    end else begin
      s_chain   <= {s_chain[SYNC_STAGES-2:0], bus.s_clk};
      s_prev    <= s_sync;
      run_chain <= {run_chain[SYNC_STAGES-2:0], bus.run_sw};
      btn_chain <= {btn_chain[SYNC_STAGES-2:0], bus.step_btn};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= btn_s;
        db_cnt <= '0;
        press  <= btn_s;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // cpu_en looks at the current state, so the tick that leaves STEP or RUN is still issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PAUSED;
      running_q    <= 1'b0;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      cpu_en_q     <= tick & ((state == RUN) || (state == STEP));
      step_count_q <= step_count_q + CNT_W'(cpu_en_q);
      case (state)
        PAUSED: begin
          if (run_s) begin
            state     <= RUN;
            running_q <= 1'b1;
          end else begin
            if (press) state <= STEP;
            running_q <= 1'b0;
          end
        end
        RUN: begin
          if (!run_s) begin
            state     <= PAUSED;
            running_q <= 1'b0;
          end else begin
            running_q <= 1'b1;
          end
        end
        STEP: begin
          if (run_s) begin
            state     <= RUN;
            running_q <= 1'b1;
          end else begin
            if (tick) state <= PAUSED;
            running_q <= 1'b0;
          end
        end
        default: begin
          state     <= PAUSED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.running    = running_q;
  assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_step_enable_gen.sv
// Randomized bench for step_enable_gen against an input-history reference model.
module tb_step_enable_gen;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned CNT_W           = 4;
  localparam int          MAXE            = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  step_enable_gen_if #(.CNT_W(CNT_W)) bus ();

  step_enable_gen #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // s_clk generator: high for the second half of a 20-cycle period, or held at s_hold.
  logic s_val   = 1'b1;
  bit   s_gen   = 1'b0;
  bit   s_hold  = 1'b1;
  int   ph      = 0;
  int   ph_init = 0;
  assign bus.s_clk = s_val;

  always @(negedge clk) begin
    if (s_gen) begin
      ph    = (ph + 1) % 20;
      s_val = (ph >= 10);
    end else begin
      ph    = ph_init;
      s_val = s_hold;
    end
  end

  // Reference model: per-edge histories of the sampled inputs and of what each
  // two-stage synchronizer presents, then the control rules applied on top.
  bit hr[MAXE], hs[MAXE], hrun[MAXE], hb[MAXE];
  bit ss[MAXE], sp[MAXE], sr[MAXE], sb[MAXE];
  int e = 0;
  int m_state = 0;          // 0 paused, 1 run, 2 step
  bit m_cpu = 0, m_run = 0, m_stable = 0, m_press = 0;
  int m_cnt = 0;
  int rises = 0, last_rise = 0, pulses = 0;

  initial begin
    hr[0] = 1'b1;
    ss[0] = 1'b1;
    sp[0] = 1'b1;
  end

  always @(posedge clk) begin : model
    bit tick, run_s, acc, in_rst;
    int ns;
    e = e + 1;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    hr[e]   = rst;
    hs[e]   = bus.s_clk;
    hrun[e] = bus.run_sw;
    hb[e]   = bus.step_btn;
    in_rst  = hr[e] || hr[e-1];
    ss[e]   = in_rst ? 1'b1 : hs[e-1];
    sr[e]   = in_rst ? 1'b0 : hrun[e-1];
    sb[e]   = in_rst ? 1'b0 : hb[e-1];
    sp[e]   = hr[e] ? 1'b1 : ss[e-1];
    if (hs[e] && !hs[e-1]) begin
      rises++;
      last_rise = e;
    end
    if (hr[e]) begin
      m_state = 0; m_cpu = 0; m_run = 0; m_cnt = 0; m_stable = 0; m_press = 0;
    end else begin
      tick  = ss[e-1] && !sp[e-1];
      run_s = sr[e-1];
      m_cnt = (m_cnt + int'(m_cpu)) % (1 << CNT_W);
      m_cpu = tick && (m_state != 0);
      ns = m_state;
      case (m_state)
        0:       ns = run_s ? 1 : (m_press ? 2 : 0);
        1:       ns = run_s ? 1 : 0;
        default: ns = run_s ? 1 : (tick ? 0 : 2);
      endcase
      m_state = ns;
      m_run   = (ns == 1);
      // a new button level is accepted after DEBOUNCE_CYCLES consecutive differing samples
      acc = (e > int'(DEBOUNCE_CYCLES));
      if (acc)
        for (int j = e - int'(DEBOUNCE_CYCLES) + 1; j <= e; j++)
          if (hr[j] || sb[j-1] == m_stable) acc = 1'b0;
      m_press = acc && !m_stable;
      if (acc) m_stable = !m_stable;
    end
  end

  always @(negedge clk) begin : monitor
    if (e > 0) begin
      check_eq("cpu_en", bus.cpu_en, m_cpu);
      check_eq("running", bus.running, m_run);
      check_eq("step_count", bus.step_count, m_cnt);
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        check_eq("latency", e - last_rise, SYNC_STAGES);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rises(input int n);
    int r0 = rises;
    int b  = 0;
    while ((rises - r0) < n && b < n * 20 + 40) begin
      @(negedge clk);
      b++;
    end
    check_eq("rise_wait", rises - r0, n);
  endtask

  task automatic press(input int n);
    bus.step_btn = 1'b1;
    cycles(n);
    bus.step_btn = 1'b0;
  endtask

  int p0;

  initial begin
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b0;

    // 1: s_clk high through reset never ticks; RUN reached 3 cycles after release
    cycles(3);
    check_eq("rst_cpu_en", bus.cpu_en, 0);
    check_eq("rst_running", bus.running, 0);
    check_eq("rst_count", bus.step_count, 0);
    rst = 1'b0;
    cycles(3);
    check_eq("t1_running", bus.running, 1);
    cycles(5);
    check_eq("t1_no_pulse", pulses, 0);
    s_gen = 1'b1;

    // 2: free-run, five rises
    p0 = pulses;
    wait_rises(5);
    cycles(4);
    check_eq("t2_pulses", pulses - p0, 5);
    check_eq("t2_count", bus.step_count, 5);

    // 3: paused, one long press gives exactly one step
    bus.run_sw = 1'b0;
    wait_rises(1);
    p0 = pulses;
    press(10);
    wait_rises(3);
    cycles(4);
    check_eq("t3_pulses", pulses - p0, 1);
    check_eq("t3_running", bus.running, 0);

    // 4: short glitches are filtered; a second press during STEP is dropped
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      press($urandom_range(1, DEBOUNCE_CYCLES - 1));
      cycles(6);
    end
    wait_rises(2);
    cycles(4);
    check_eq("t4_glitch", pulses - p0, 0);
    wait_rises(1);
    p0 = pulses;
    press(5);
    cycles(5);
    press(5);
    wait_rises(2);
    cycles(4);
    check_eq("t4_two_press", pulses - p0, 1);

    // 5: counter wrap after 17 issued enables
    s_gen   = 1'b0;
    s_hold  = 1'b0;
    ph_init = 0;
    rst     = 1'b1;
    bus.run_sw = 1'b1;
    cycles(3);
    rst   = 1'b0;
    s_gen = 1'b1;
    p0 = pulses;
    wait_rises(17);
    cycles(4);
    check_eq("t5_pulses", pulses - p0, 17);
    check_eq("t5_wrap", bus.step_count, 1);

    // 6: reset while in STEP discards the pending step
    bus.run_sw = 1'b0;
    wait_rises(1);
    press(10);
    cycles(2);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    check_eq("t6_cnt_reset", bus.step_count, 0);
    p0 = pulses;
    wait_rises(2);
    cycles(4);
    check_eq("t6_pulses", pulses - p0, 0);
    check_eq("t6_count", bus.step_count, 0);
    check_eq("t6_running", bus.running, 0);

    // random run/pause and button activity, checked cycle by cycle by the model
    repeat (40) begin
      bus.run_sw   = ($urandom_range(0, 3) == 0);
      bus.step_btn = $urandom_range(0, 1);
      cycles($urandom_range(1, 12));
    end
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    cycles(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
